pixel_write_buffer: RTL and testbench

PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

---
 rtl/pixel_write_buffer.sv | 176 +++++++++++++++++
 tb/tb_pixel_write_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// Ping-pong pixel buffer that drains two DEPTH-entry banks to an Avalon-MM write master.
// Latency: a full or last-partial bank starts draining the cycle after it closes; done follows the last accepted write by one cycle.
// Backpressure: pixel_ready drops while the fill bank is full; master_waitrequest freezes address/data until accepted.
module pixel_write_buffer #(
  parameter int PIXEL_W   = 24,
  parameter int DEPTH     = 6,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [19:0]        total_pixels,
  input  logic               pixel_valid,
  input  logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_ready,
  output logic               master_write,
  output logic [ADDR_W-1:0]  master_address,
  output logic [PIXEL_W-1:0] master_writedata,
  input  logic               master_waitrequest,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Per-bank bookkeeping: a bank is either filling (full=0) or draining (full=1).
  typedef struct packed {
    logic             full;
    logic [CNT_W-1:0] cnt;
  } bank_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [19:0]        total_q;
  logic [19:0]        acc_cnt;
  logic [19:0]        wr_cnt;
  bank_t              bank [2];
  logic               fill_ptr;
  logic               drain_ptr;
  logic [CNT_W-1:0]   drain_idx;
  logic [PIXEL_W-1:0] mem [2][DEPTH];

  bank_t              fill_bank;
  bank_t              drain_bank;
  logic [CNT_W-1:0]   fill_cnt_inc;
  logic [CNT_W-1:0]   drain_idx_inc;
  logic               start_acc;
  logic               pix_acc;
  logic               wr_acc;
  logic               fill_close;
  logic               drain_close;
  logic               last_write;

  // Decode handshakes and bank-boundary events from the current register state.
  always_comb begin
    fill_bank     = bank[fill_ptr];
    drain_bank    = bank[drain_ptr];
    fill_cnt_inc  = fill_bank.cnt + ONE_C;
    drain_idx_inc = drain_idx + ONE_C;
    start_acc     = start && (state == IDLE);
    pix_acc       = pixel_valid && pixel_ready;
    wr_acc        = master_write && !master_waitrequest;
    // A bank closes when it fills up or when it holds the final pixel of the transfer.
    fill_close    = pix_acc && ((fill_cnt_inc == DEPTH_C) || ((acc_cnt + 20'd1) == total_q));
    drain_close   = wr_acc && (drain_idx_inc == drain_bank.cnt);
    last_write    = wr_acc && ((wr_cnt + 20'd1) == total_q);
  end

  // Output decode: all terms come straight from registers, so they hold steady under waitrequest.
  always_comb begin
    pixel_ready      = (state == RUN) && !fill_bank.full && (acc_cnt < total_q);
    master_write     = (state == RUN) && drain_bank.full;
    master_address   = addr_q;
    master_writedata = master_write ? mem[drain_ptr][drain_idx[IDX_W-1:0]] : '0;
  end

  // Top-level control FSM with registered busy/done and the running write address.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr_q  <= '0;
      total_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_q  <= base_addr;
            total_q <= total_pixels;
            if (total_pixels == 20'd0) begin
              // Nothing to move: report completion without entering RUN.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_acc) begin
            addr_q <= addr_q + STEP_C;
          end
          if (last_write) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Bank fill/drain bookkeeping; the fill and drain banks always differ, so both updates can land together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      bank[0]   <= '0;
      bank[1]   <= '0;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      drain_idx <= '0;
    end else begin
      if (start_acc) begin
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end
      if (pix_acc) begin
        acc_cnt <= acc_cnt + 20'd1;
        bank[fill_ptr].cnt <= fill_cnt_inc;
        if (fill_close) begin
          bank[fill_ptr].full <= 1'b1;
          fill_ptr            <= ~fill_ptr;
        end
      end
      if (wr_acc) begin
        wr_cnt <= wr_cnt + 20'd1;
        if (drain_close) begin
          bank[drain_ptr] <= '0;
          drain_idx       <= '0;
          drain_ptr       <= ~drain_ptr;
        end else begin
          drain_idx <= drain_idx_inc;
        end
      end
    end
  end

  // Pixel storage: each accepted pixel lands at the fill bank's current count.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      mem[fill_ptr][fill_bank.cnt[IDX_W-1:0]] <= pixel_data;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: stimulus pushes expected writes, a monitor pops and compares.
// Slave stalls are generated per write with a programmable waitrequest length.
// Pixel source honours pixel_ready and can be aborted when reset is pulled mid-transfer.
`timescale 1ns/1ps
module tb_pixel_write_buffer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [19:0] total_pixels = '0;
  logic        pixel_valid = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_ready;
  logic        master_write;
  logic [31:0] master_address;
  logic [23:0] master_writedata;
  logic        master_waitrequest = 1'b0;
  logic        busy;
  logic        done;

  pixel_write_buffer #(
    .PIXEL_W(24), .DEPTH(6), .ADDR_W(32), .ADDR_STEP(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .total_pixels(total_pixels), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_ready(pixel_ready), .master_write(master_write), .master_address(master_address),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  int          writes_seen = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = '0;
  bit          saw_ready_low = 1'b0;
  int          stall_n = 0;
  int          stall_cnt = 0;
  bit          abort_tx = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: sample mid-cycle; a write with waitrequest low is accepted at the next rising edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (master_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   master_address, master_writedata);
        end else if (master_waitrequest) begin
          chk("stall_addr", 64'(master_address), 64'(exp_q[0].addr));
          chk("stall_data", 64'(master_writedata), 64'(exp_q[0].data));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(master_address), 64'(mon_e.addr));
          chk("wr_data", 64'(master_writedata), 64'(mon_e.data));
          writes_seen++;
          last_addr = master_address;
        end
      end
      if (done) done_cnt++;
      if (pixel_valid && !pixel_ready && busy) saw_ready_low = 1'b1;
    end
  end

  // Slave model: hold waitrequest high for stall_n cycles on every write, then accept.
  always @(posedge clk) begin
    #1;
    if (!n_rst || stall_n == 0 || !master_write) begin
      master_waitrequest = 1'b0;
      stall_cnt = 0;
    end else if (stall_cnt < stall_n) begin
      master_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      master_waitrequest = 1'b0;
      stall_cnt = 0;
    end
  end

  task automatic do_start(input logic [31:0] b, input int t);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    total_pixels = 20'(t);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [7:0] tag);
    bit r;
    int guard;
    for (int i = 0; i < n && !abort_tx; i++) begin
      pixel_valid = 1'b1;
      pixel_data = {tag, 16'(i)};
      r = 1'b0;
      guard = 0;
      while (!r && !abort_tx) begin
        @(negedge clk);
        r = pixel_ready;
        @(posedge clk); #1;
        guard++;
        if (guard > 300) begin
          fail_timeout("pixel_accept");
          pixel_valid = 1'b0;
          return;
        end
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int total, input logic [7:0] tag,
                          input int stall, input bit mid_start, input string name);
    wr_t tmp;
    int guard;
    for (int i = 0; i < total; i++) begin
      tmp.addr = base + 32'(i * 4);
      tmp.data = {tag, 16'(i)};
      exp_q.push_back(tmp);
    end
    done_cnt = 0;
    writes_seen = 0;
    saw_ready_low = 1'b0;
    stall_n = stall;
    do_start(base, total);
    if (total > 0) chk({name, "_busy"}, 64'(busy), 64'd1);
    fork
      send_pixels(total, tag);
      begin
        if (mid_start) begin
          repeat (3) @(posedge clk);
          #1;
          start = 1'b1;
          base_addr = 32'h9000;
          total_pixels = 20'd3;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (done_cnt == 0) fail_timeout({name, "_done"});
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, "_write_count"}, 64'(writes_seen), 64'(total));
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    stall_n = 0;
  endtask

  initial begin
    int guard;
    // Reset state
    n_rst = 1'b0;
    #12;
    chk("rst_master_write", 64'(master_write), 64'd0);
    chk("rst_master_address", 64'(master_address), 64'd0);
    chk("rst_master_writedata", 64'(master_writedata), 64'd0);
    chk("rst_pixel_ready", 64'(pixel_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Pixels offered while idle must not be taken
    @(posedge clk); #1;
    pixel_valid = 1'b1;
    pixel_data = 24'hBADBAD;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 64'(pixel_ready), 64'd0);
    end
    pixel_valid = 1'b0;

    run_xfer(32'h1000, 12, 8'h01, 0, 1'b0, "t12");
    chk("t12_last_addr", 64'(last_addr), 64'h102C);

    run_xfer(32'h1000, 8, 8'h02, 3, 1'b0, "t8stall");
    chk("t8stall_last_addr", 64'(last_addr), 64'h101C);

    run_xfer(32'h1000, 18, 8'h03, 3, 1'b0, "t18stall");
    chk("t18stall_ready_dropped", 64'(saw_ready_low), 64'd1);

    run_xfer(32'h1000, 9, 8'h04, 0, 1'b0, "t9");
    chk("t9_last_addr", 64'(last_addr), 64'h1020);

    run_xfer(32'h1000, 0, 8'h00, 0, 1'b0, "t0");

    run_xfer(32'h2000, 12, 8'h07, 0, 1'b1, "midstart");
    chk("midstart_last_addr", 64'(last_addr), 64'h202C);

    // Reset in the middle of a 12-pixel transfer
    for (int i = 0; i < 12; i++) begin
      mon_e.addr = 32'h3000 + 32'(i * 4);
      mon_e.data = {8'h05, 16'(i)};
      exp_q.push_back(mon_e);
    end
    writes_seen = 0;
    done_cnt = 0;
    do_start(32'h3000, 12);
    fork
      send_pixels(12, 8'h05);
      begin
        guard = 0;
        while (writes_seen < 4 && guard < 500) begin
          @(negedge clk); #1;
          guard++;
        end
        if (writes_seen < 4) fail_timeout("abort_wait_writes");
        @(posedge clk); #2;
        n_rst = 1'b0;
        abort_tx = 1'b1;
        #1;
        chk("abort_writes_before", 64'(writes_seen), 64'd4);
        chk("abort_master_write", 64'(master_write), 64'd0);
        chk("abort_master_address", 64'(master_address), 64'd0);
        chk("abort_master_writedata", 64'(master_writedata), 64'd0);
        chk("abort_pixel_ready", 64'(pixel_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
      end
    join
    exp_q.delete();
    pixel_valid = 1'b0;
    abort_tx = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);

    run_xfer(32'h5000, 6, 8'h06, 0, 1'b0, "post_reset");
    chk("post_reset_last_addr", 64'(last_addr), 64'h5014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
